// File: rtl/tdc_pkg.sv
// rtl/tdc_pkg.sv - shared constants and state type for the TDC thermometer generator
package tdc_pkg;

    localparam int TDC_WIDTH   = 40;
    localparam int TDC_CW      = 8;
    localparam int TDC_MAXCODE = 39;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SINGLE = 2'd1,
        SWEEP  = 2'd2,
        DONE   = 2'd3
    } tg_state_t;

endpackage

// File: rtl/tdc_thermo_decode.sv
// rtl/tdc_thermo_decode.sv - binary bin code to delay-line thermometer word, with optional bubble
module tdc_thermo_decode
    import tdc_pkg::*;
#(
    parameter int WIDTH = TDC_WIDTH,
    parameter int CW    = TDC_CW
) (
    input  logic [CW-1:0]    code_i,
    input  logic             bubble_i,
    output logic [WIDTH-1:0] therm_o
);

    // Taps below the code are set; the top tap is never set; a bubble clears tap 0 for codes >= 3
    always_comb begin
        therm_o = '0;
        for (int i = 0; i < WIDTH - 1; i++) begin
            therm_o[i] = (int'(code_i) > i);
        end
        if (bubble_i && (code_i >= CW'(3))) begin
            therm_o[0] = 1'b0;
        end
    end

endmodule

// File: rtl/tdc_thermo_gen.sv
// rtl/tdc_thermo_gen.sv - self-test thermometer pattern generator (single pattern or full sweep)
module tdc_thermo_gen
    import tdc_pkg::*;
#(
    parameter int WIDTH = TDC_WIDTH,
    parameter int CW    = TDC_CW,
    parameter int HOLD  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic [CW-1:0]    code_in,
    input  logic             bubble_en,
    input  logic             abort,
    output logic             busy,
    output logic [WIDTH-1:0] therm_out,
    output logic             therm_valid,
    output logic [CW-1:0]    code_exp,
    output logic             done,
    output logic             err
);

    localparam int          HW       = $clog2(HOLD + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);
    localparam logic [CW-1:0] MAX_CODE  = CW'(WIDTH - 1);

    tg_state_t         state_q, state_d;
    logic [HW-1:0]     hold_q, hold_d;
    logic [CW-1:0]     code_q, code_d;
    logic              bubble_q, bubble_d;

    logic              busy_d, valid_d, done_d, err_d;
    logic [WIDTH-1:0]  therm_d, therm_dec;
    logic [CW-1:0]     code_exp_d;
    logic              run_d;

    // The decoder looks at the next-cycle code so its result can be registered straight to therm_out
    tdc_thermo_decode #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_decode (
        .code_i   (code_d),
        .bubble_i (bubble_d),
        .therm_o  (therm_dec)
    );

    // State, counter and latched-request registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            hold_q   <= '0;
            code_q   <= '0;
            bubble_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            hold_q   <= hold_d;
            code_q   <= code_d;
            bubble_q <= bubble_d;
        end
    end

    // Next state and counters; abort outranks hold wrap and completion
    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        code_d   = code_q;
        bubble_d = bubble_q;
        err_d    = 1'b0;
        case (state_q)
            IDLE: begin
                hold_d = '0;
                if (start && !abort) begin
                    if (mode) begin
                        state_d  = SWEEP;
                        code_d   = '0;
                        bubble_d = bubble_en;
                    end else if (code_in <= MAX_CODE) begin
                        state_d  = SINGLE;
                        code_d   = code_in;
                        bubble_d = bubble_en;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            SINGLE: begin
                if (abort) begin
                    state_d = IDLE;
                    hold_d  = '0;
                    code_d  = '0;
                end else if (hold_q == HOLD_LAST) begin
                    state_d = DONE;
                    hold_d  = '0;
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            SWEEP: begin
                if (abort) begin
                    state_d = IDLE;
                    hold_d  = '0;
                    code_d  = '0;
                end else if (hold_q == HOLD_LAST) begin
                    hold_d = '0;
                    if (code_q == MAX_CODE) begin
                        state_d = DONE;
                    end else begin
                        code_d = code_q + CW'(1);
                    end
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
                hold_d  = '0;
                code_d  = '0;
            end
            default: begin
                state_d = IDLE;
                hold_d  = '0;
                code_d  = '0;
            end
        endcase
    end

    // Output values for the coming cycle, derived from the next state
    always_comb begin
        run_d      = (state_d == SINGLE) || (state_d == SWEEP);
        busy_d     = (state_d != IDLE);
        valid_d    = run_d;
        done_d     = (state_d == DONE);
        therm_d    = run_d ? therm_dec : '0;
        code_exp_d = run_d ? code_d : '0;
    end

    // Every output comes straight from a flop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy        <= 1'b0;
            therm_valid <= 1'b0;
            therm_out   <= '0;
            code_exp    <= '0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            busy        <= busy_d;
            therm_valid <= valid_d;
            therm_out   <= therm_d;
            code_exp    <= code_exp_d;
            done        <= done_d;
            err         <= err_d;
        end
    end

endmodule

// File: tb/tb_tdc_thermo_gen.sv
// tb/tb_tdc_thermo_gen.sv - self-checking bench for tdc_thermo_gen with HOLD=4 and HOLD=1 instances
module tb_tdc_thermo_gen;

    typedef struct packed {
        logic        busy;
        logic        valid;
        logic [39:0] therm;
        logic [7:0]  code;
        logic        done;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, mode, bubble_en, abort;
    logic [7:0]  code_in;

    logic        busy4, valid4, done4, err4;
    logic [39:0] therm4;
    logic [7:0]  code4;
    logic        busy1, valid1, done1, err1;
    logic [39:0] therm1;
    logic [7:0]  code1;

    int n_assert = 0;
    int n_fail   = 0;

    exp_t mq [2][$];
    exp_t cur [2];
    int   holds [2] = '{4, 1};

    always #5 clk = ~clk;

    tdc_thermo_gen #(.WIDTH(40), .CW(8), .HOLD(4)) dut_h4 (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .code_in(code_in),
        .bubble_en(bubble_en), .abort(abort), .busy(busy4), .therm_out(therm4),
        .therm_valid(valid4), .code_exp(code4), .done(done4), .err(err4)
    );

    tdc_thermo_gen #(.WIDTH(40), .CW(8), .HOLD(1)) dut_h1 (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .code_in(code_in),
        .bubble_en(bubble_en), .abort(abort), .busy(busy1), .therm_out(therm1),
        .therm_valid(valid1), .code_exp(code1), .done(done1), .err(err1)
    );

    function automatic logic [39:0] therm_of(int k, bit bub);
        logic [39:0] t;
        t = (40'd1 << k) - 40'd1;
        if (bub && k >= 3) t[0] = 1'b0;
        return t;
    endfunction

    function automatic exp_t pat(int k, bit bub);
        exp_t e;
        e = '0;
        e.busy  = 1'b1;
        e.valid = 1'b1;
        e.therm = therm_of(k, bub);
        e.code  = 8'(k);
        return e;
    endfunction

    // Reference: on an accepted start, the whole per-cycle output sequence of the run is queued
    task automatic model_step(input int d);
        exp_t z;
        exp_t dn;
        z  = '0;
        dn = '0;
        dn.busy = 1'b1;
        dn.done = 1'b1;
        if (!rst_n) begin
            mq[d].delete();
            cur[d] = z;
        end else if (cur[d].busy) begin
            if (abort) begin
                mq[d].delete();
                cur[d] = z;
            end else if (mq[d].size() > 0) begin
                cur[d] = mq[d].pop_front();
            end else begin
                cur[d] = z;
            end
        end else begin
            cur[d] = z;
            if (start && !abort) begin
                if (mode) begin
                    for (int k = 0; k < 40; k++)
                        for (int h = 0; h < holds[d]; h++) mq[d].push_back(pat(k, bubble_en));
                    mq[d].push_back(dn);
                    cur[d] = mq[d].pop_front();
                end else if (int'(code_in) <= 39) begin
                    for (int h = 0; h < holds[d]; h++) mq[d].push_back(pat(int'(code_in), bubble_en));
                    mq[d].push_back(dn);
                    cur[d] = mq[d].pop_front();
                end else begin
                    cur[d].err = 1'b1;
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_assert++;
        assert (obs === expv)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic compare_all();
        exp_t o4, o1;
        o4 = {busy4, valid4, therm4, code4, done4, err4};
        o1 = {busy1, valid1, therm1, code1, done1, err1};
        chk("cyc_h4", 64'(o4), 64'(cur[0]));
        chk("cyc_h1", 64'(o1), 64'(cur[1]));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        compare_all();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        int guard;
        rst_n = 1'b0; start = 0; mode = 0; bubble_en = 0; abort = 0; code_in = '0;
        cur[0] = '0;
        cur[1] = '0;
        run(2);
        rst_n = 1'b1;
        run(2);

        // Single, code 5
        start = 1; mode = 0; code_in = 8'd5;
        cycle();
        start = 0;
        chk("single5_therm", 64'(therm4), 64'h00_0000_001F);
        chk("single5_code", 64'(code4), 64'h05);
        run(3);
        chk("single5_valid_last", 64'(valid4), 64'd1);
        cycle();
        chk("single5_done", 64'(done4), 64'd1);
        cycle();
        chk("single5_idle", 64'(busy4), 64'd0);

        // Rejected code 40
        start = 1; code_in = 8'd40;
        cycle();
        start = 0;
        chk("err40_pulse", 64'(err4), 64'd1);
        chk("err40_busy", 64'(busy4), 64'd0);
        chk("err40_therm", 64'(therm4), 64'd0);
        cycle();
        chk("err40_one_cycle", 64'(err4), 64'd0);

        // Boundary codes 39 and 0
        start = 1; code_in = 8'd39;
        cycle();
        start = 0;
        chk("code39_therm", 64'(therm4), 64'h7F_FFFF_FFFF);
        chk("code39_code", 64'(code4), 64'h27);
        run(6);
        start = 1; code_in = 8'd0;
        cycle();
        start = 0;
        chk("code0_valid", 64'(valid4), 64'd1);
        chk("code0_therm", 64'(therm4), 64'd0);
        run(6);

        // Bubble
        start = 1; code_in = 8'd5; bubble_en = 1;
        cycle();
        start = 0; bubble_en = 0;
        chk("bubble5_therm", 64'(therm4), 64'h1E);
        chk("bubble5_code", 64'(code4), 64'h05);
        run(6);
        start = 1; code_in = 8'd2; bubble_en = 1;
        cycle();
        start = 0; bubble_en = 0;
        chk("bubble2_therm", 64'(therm4), 64'h03);
        run(6);

        // Sweep; HOLD=1 instance finishes in cycle 41, start while busy is ignored
        start = 1; mode = 1;
        cycle();
        start = 0; mode = 0;
        for (int i = 1; i <= 40; i++) begin
            if (i > 1) cycle();
            if (i == 5) begin
                start = 1; code_in = 8'd7;
            end else begin
                start = 0;
            end
            chk("sweep_h1_code", 64'(code1), 64'(i - 1));
            chk("sweep_h1_therm", 64'(therm1), 64'(therm_of(i - 1, 1'b0)));
        end
        start = 0;
        cycle();
        chk("sweep_h1_done", 64'(done1), 64'd1);
        chk("sweep_h4_k10", 64'(code4), 64'd10);
        abort = 1;
        cycle();
        abort = 0;
        chk("abort_valid", 64'(valid4), 64'd0);
        chk("abort_done", 64'(done4), 64'd0);
        chk("abort_busy", 64'(busy4), 64'd0);
        run(3);

        // Async reset mid-sweep at k=17
        start = 1; mode = 1;
        cycle();
        start = 0; mode = 0;
        guard = 0;
        while (code4 != 8'd17 && guard < 300) begin
            cycle();
            guard++;
        end
        chk("reach_k17", 64'(code4), 64'd17);
        #2;
        rst_n = 1'b0;
        #1;
        mq[0].delete(); mq[1].delete();
        cur[0] = '0; cur[1] = '0;
        compare_all();
        cycle();
        rst_n = 1'b1;
        cycle();
        start = 1; code_in = 8'd9;
        cycle();
        start = 0;
        chk("post_reset_single", 64'(therm4), 64'h1FF);
        run(6);

        // Random traffic against the queue model
        for (int i = 0; i < 2000; i++) begin
            start     = ($urandom % 6) == 0;
            mode      = ($urandom % 5) == 0;
            code_in   = 8'($urandom_range(0, 45));
            bubble_en = $urandom % 2;
            abort     = ($urandom % 40) == 0;
            cycle();
        end
        start = 0; abort = 0;
        run(200);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
